// File: rtl/pwm_frame_scheduler.sv
// Frame-aligned RGBW PWM scheduler: prescaled tick, shadowed duty, drain on stop.
// Optional: define PWM_FULL_SCALE_EN for a true 100% output at all-ones duty.
module pwm_frame_scheduler #(
  parameter int CNT_W   = 8,
  parameter int NUM_CH  = 4,
  parameter int PRESC_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [PRESC_W-1:0]      presc_div,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  input  logic [NUM_CH*CNT_W-1:0] upd_duty,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    frame_start,
  output logic                    running
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state, stateNext;

  logic [PRESC_W-1:0]      prescCnt;
  logic [PRESC_W-1:0]      divActive;
  logic [CNT_W-1:0]        pwmCnt;
  logic [NUM_CH*CNT_W-1:0] dutyActive;
  logic [NUM_CH*CNT_W-1:0] dutyPending;
  logic                    pendFull;
  logic                    accept;
  logic                    tick;
  logic                    wrap;
  logic [NUM_CH-1:0]       pwmCmp;

  assign upd_ready = (state == IDLE) || !pendFull;
  assign accept    = upd_valid && upd_ready;
  assign tick      = (state != IDLE) && (prescCnt == divActive);
  assign wrap      = tick && (pwmCnt == CNT_MAX);

  always_comb begin
    pwmCmp = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pwmCmp[i] = pwmCnt < dutyActive[i*CNT_W +: CNT_W];
`ifdef PWM_FULL_SCALE_EN
      if (dutyActive[i*CNT_W +: CNT_W] == CNT_MAX)
        pwmCmp[i] = 1'b1;
`endif
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (enable) stateNext = RUN;
      RUN:     if (!enable) stateNext = DRAIN;
      DRAIN: begin
        if (enable)    stateNext = RUN;
        else if (wrap) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prescCnt    <= '0;
      divActive   <= '0;
      pwmCnt      <= '0;
      dutyActive  <= '0;
      dutyPending <= '0;
      pendFull    <= 1'b0;
      pwm_out     <= '0;
      frame_start <= 1'b0;
      running     <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      running     <= (stateNext != IDLE);
      if (state == IDLE) begin
        prescCnt <= '0;
        pwmCnt   <= '0;
        pwm_out  <= '0;
        if (accept) dutyActive <= upd_duty;
        if (enable) begin
          divActive   <= presc_div;
          frame_start <= 1'b1;
        end
      end else if (stateNext == IDLE) begin
        // last wrap of a drain: land any update so IDLE sees it
        prescCnt  <= '0;
        pwmCnt    <= '0;
        pwm_out   <= '0;
        pendFull  <= 1'b0;
        divActive <= presc_div;
        if (accept)        dutyActive <= upd_duty;
        else if (pendFull) dutyActive <= dutyPending;
      end else begin
        pwm_out <= pwmCmp;
        if (tick) begin
          prescCnt <= '0;
          pwmCnt   <= pwmCnt + 1'b1;
        end else begin
          prescCnt <= prescCnt + 1'b1;
        end
        if (wrap) begin
          divActive   <= presc_div;
          frame_start <= 1'b1;
          if (pendFull) begin
            dutyActive <= dutyPending;
            pendFull   <= 1'b0;
          end
        end
        if (accept) begin
          dutyPending <= upd_duty;
          pendFull    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_frame_scheduler.sv
// Testbench for pwm_frame_scheduler: directed frame scenarios plus
// randomized traffic against a frame-timing reference model.
module tb_pwm_frame_scheduler;

  localparam int CNT_W   = 8;
  localparam int NUM_CH  = 4;
  localparam int PRESC_W = 8;
  localparam int FRAME   = 1 << CNT_W;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    enable;
  logic [PRESC_W-1:0]      presc_div;
  logic                    upd_valid;
  logic                    upd_ready;
  logic [NUM_CH*CNT_W-1:0] upd_duty;
  logic [NUM_CH-1:0]       pwm_out;
  logic                    frame_start;
  logic                    running;

  int checks = 0;
  int errors = 0;

  // reference model: frame timing derived from start cycle and divider
  bit mValid, mRun, mDrain, mPend;
  int mStart, mDiv, cyc;
  int mDuty[NUM_CH];
  int mPendVal[NUM_CH];
  int hi[NUM_CH];

  always #5 clk = ~clk;

  pwm_frame_scheduler #(
    .CNT_W(CNT_W),
    .NUM_CH(NUM_CH),
    .PRESC_W(PRESC_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .presc_div(presc_div),
    .upd_valid(upd_valid),
    .upd_ready(upd_ready),
    .upd_duty(upd_duty),
    .pwm_out(pwm_out),
    .frame_start(frame_start),
    .running(running)
  );

  function automatic bit onLevel(int cnt, int duty);
`ifdef PWM_FULL_SCALE_EN
    if (duty == FRAME - 1) return 1'b1;
`endif
    return cnt < duty;
  endfunction

  function automatic logic [NUM_CH*CNT_W-1:0] pack(int r, int g, int b, int w);
    return {CNT_W'(w), CNT_W'(b), CNT_W'(g), CNT_W'(r)};
  endfunction

  function automatic int pickDuty();
    int sel;
    sel = int'($urandom_range(0, 3));
    if (sel == 0) return 0;
    if (sel == 1) return FRAME - 1;
    return int'($urandom_range(0, FRAME - 1));
  endfunction

  task automatic step();
    bit rdy, acc, wrapNow, drainEnd, expFs, expRdy;
    logic [NUM_CH-1:0] expPwm;
    int cnt;
    rdy    = !mRun || !mPend;
    acc    = upd_valid && rdy;
    expPwm = '0;
    @(posedge clk);
    if (reset) begin
      mValid = 1'b1;
      mRun   = 1'b0;
      mDrain = 1'b0;
      mPend  = 1'b0;
      for (int i = 0; i < NUM_CH; i++) mDuty[i] = 0;
    end else if (mValid) begin
      if (!mRun) begin
        if (acc)
          for (int i = 0; i < NUM_CH; i++)
            mDuty[i] = int'(upd_duty[i*CNT_W +: CNT_W]);
        if (enable) begin
          mRun   = 1'b1;
          mDrain = 1'b0;
          mStart = cyc + 1;
          mDiv   = int'(presc_div);
        end
      end else begin
        cnt      = (cyc - mStart) / (mDiv + 1);
        wrapNow  = (cyc == mStart + FRAME * (mDiv + 1) - 1);
        drainEnd = wrapNow && mDrain && !enable;
        if (!drainEnd)
          for (int i = 0; i < NUM_CH; i++)
            expPwm[i] = onLevel(cnt, mDuty[i]);
        if (wrapNow) begin
          if (mPend) begin
            mDuty = mPendVal;
            mPend = 1'b0;
          end
          mDiv   = int'(presc_div);
          mStart = cyc + 1;
        end
        if (acc) begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (drainEnd) mDuty[i] = int'(upd_duty[i*CNT_W +: CNT_W]);
            else mPendVal[i] = int'(upd_duty[i*CNT_W +: CNT_W]);
          end
          if (!drainEnd) mPend = 1'b1;
        end
        if (mDrain) begin
          if (enable) mDrain = 1'b0;
          else if (wrapNow) mRun = 1'b0;
        end else if (!enable) begin
          mDrain = 1'b1;
        end
      end
    end
    cyc++;
    expFs  = mRun && (mStart == cyc);
    expRdy = !mRun || !mPend;
    @(negedge clk);
    if (mValid) begin
      checks++;
      if (pwm_out !== expPwm) begin
        errors++;
        $display("FAIL pwm_out cyc=%0d got=%b exp=%b", cyc, pwm_out, expPwm);
      end
      checks++;
      if (frame_start !== expFs) begin
        errors++;
        $display("FAIL frame_start cyc=%0d got=%b exp=%b", cyc, frame_start, expFs);
      end
      checks++;
      if (running !== mRun) begin
        errors++;
        $display("FAIL running cyc=%0d got=%b exp=%b", cyc, running, mRun);
      end
      checks++;
      if (upd_ready !== expRdy) begin
        errors++;
        $display("FAIL upd_ready cyc=%0d got=%b exp=%b", cyc, upd_ready, expRdy);
      end
    end
  endtask

  task automatic waitFrame();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (frame_start !== 1'b1 && n < 4000);
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL wait_frame timeout got=%b exp=1 after %0d cycles", frame_start, n);
    end
  endtask

  task automatic countFrame(input int len);
    for (int i = 0; i < NUM_CH; i++) hi[i] = 0;
    for (int n = 0; n < len; n++) begin
      step();
      for (int i = 0; i < NUM_CH; i++)
        if (pwm_out[i] === 1'b1) hi[i]++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if (pwm_out !== '0 || frame_start !== 1'b0 || running !== 1'b0 || upd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got pwm=%b fs=%b run=%b rdy=%b exp 0000/0/0/1",
               pwm_out, frame_start, running, upd_ready);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int expB;
`ifdef PWM_FULL_SCALE_EN
    expB = 512;
`else
    expB = 510;
`endif
    presc_div = 8'd1;
    upd_duty  = pack(64, 0, 255, 128);
    upd_valid = 1'b1;
    step();
    upd_valid = 1'b0;
    enable    = 1'b1;
    waitFrame();
    for (int f = 0; f < 2; f++) begin
      countFrame(512);
      checks++;
      if (hi[0] !== 128 || hi[1] !== 0 || hi[2] !== expB || hi[3] !== 256) begin
        errors++;
        $display("FAIL basic_high f=%0d got %0d/%0d/%0d/%0d exp 128/0/%0d/256",
                 f, hi[0], hi[1], hi[2], hi[3], expB);
      end
      checks++;
      if (frame_start !== 1'b1) begin
        errors++;
        $display("FAIL basic_period got fs=%b exp=1 at 512 clk", frame_start);
      end
    end
  endtask

  task automatic test_midframe_update();
    int r;
    r = 0;
    for (int n = 0; n < 512; n++) begin
      if (n == 100) begin
        upd_duty  = pack(200, 0, 255, 128);
        upd_valid = 1'b1;
      end
      step();
      upd_valid = 1'b0;
      if (pwm_out[0] === 1'b1) r++;
      if (n == 101) begin
        checks++;
        if (upd_ready !== 1'b0) begin
          errors++;
          $display("FAIL mid_ready got=%b exp=0", upd_ready);
        end
      end
    end
    checks++;
    if (r !== 128) begin
      errors++;
      $display("FAIL mid_old_frame got=%0d exp=128", r);
    end
    countFrame(512);
    checks++;
    if (hi[0] !== 400) begin
      errors++;
      $display("FAIL mid_new_frame got=%0d exp=400", hi[0]);
    end
  endtask

  task automatic test_wrap_offer();
    int r;
    for (int n = 0; n < 511; n++) step();
    upd_duty  = pack(32, 0, 255, 128);
    upd_valid = 1'b1;
    step();
    checks++;
    if (frame_start !== 1'b1 || upd_ready !== 1'b0) begin
      errors++;
      $display("FAIL wrap_offer got fs=%b rdy=%b exp fs=1 rdy=0", frame_start, upd_ready);
    end
    upd_duty = pack(16, 0, 255, 128);
    r = 0;
    for (int n = 0; n < 512; n++) begin
      if (n == 20) upd_valid = 1'b0;
      step();
      if (pwm_out[0] === 1'b1) r++;
    end
    checks++;
    if (r !== 400) begin
      errors++;
      $display("FAIL wrap_not_applied got=%0d exp=400", r);
    end
    countFrame(512);
    checks++;
    if (hi[0] !== 64) begin
      errors++;
      $display("FAIL wrap_applied_next got=%0d exp=64", hi[0]);
    end
  endtask

  task automatic test_presc_change();
    for (int n = 0; n < 512; n++) begin
      if (n == 100) presc_div = 8'd3;
      step();
    end
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL presc_old_period got fs=%b exp=1 at 512 clk", frame_start);
    end
    countFrame(1024);
    checks++;
    if (frame_start !== 1'b1 || hi[0] !== 128) begin
      errors++;
      $display("FAIL presc_new_period got fs=%b high=%0d exp fs=1 high=128",
               frame_start, hi[0]);
    end
  endtask

  task automatic test_drain();
    presc_div = 8'd0;
    waitFrame();
    for (int n = 0; n < 10; n++) step();
    enable = 1'b0;
    for (int n = 0; n < 245; n++) step();
    checks++;
    if (running !== 1'b1) begin
      errors++;
      $display("FAIL drain_running got=%b exp=1", running);
    end
    step();
    checks++;
    if (running !== 1'b0 || pwm_out !== '0 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL drain_idle got run=%b pwm=%b fs=%b exp 0/0000/0",
               running, pwm_out, frame_start);
    end
    for (int n = 0; n < 5; n++) step();
    enable = 1'b1;
    waitFrame();
    for (int n = 0; n < 256; n++) begin
      if (n == 20) enable = 1'b0;
      if (n == 50) enable = 1'b1;
      step();
    end
    checks++;
    if (frame_start !== 1'b1 || running !== 1'b1) begin
      errors++;
      $display("FAIL drain_rearm got fs=%b run=%b exp 1/1", frame_start, running);
    end
  endtask

  task automatic test_reset_mid();
    upd_duty  = pack(99, 0, 77, 0);
    upd_valid = 1'b1;
    step();
    upd_valid = 1'b0;
    for (int n = 0; n < 5; n++) step();
    checks++;
    if (upd_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_pending got rdy=%b exp=0", upd_ready);
    end
    enable = 1'b0;
    reset  = 1'b1;
    step();
    checks++;
    if (pwm_out !== '0 || running !== 1'b0 || frame_start !== 1'b0 || upd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_state got pwm=%b run=%b fs=%b rdy=%b exp 0000/0/0/1",
               pwm_out, running, frame_start, upd_ready);
    end
    reset = 1'b0;
    for (int n = 0; n < 3; n++) step();
    enable = 1'b1;
    waitFrame();
    countFrame(256);
    checks++;
    if (hi[0] !== 0 || hi[2] !== 0) begin
      errors++;
      $display("FAIL rstmid_discard got R=%0d B=%0d exp 0/0", hi[0], hi[2]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 12000; n++) begin
      if (!upd_valid && $urandom_range(0, 99) < 3) begin
        upd_valid = 1'b1;
        for (int i = 0; i < NUM_CH; i++)
          upd_duty[i*CNT_W +: CNT_W] = CNT_W'(pickDuty());
      end else if (upd_valid && $urandom_range(0, 99) < 20) begin
        upd_valid = 1'b0;
      end
      if ($urandom_range(0, 99) == 0)
        presc_div = PRESC_W'($urandom_range(0, 2));
      if ($urandom_range(0, 999) < 3)
        enable = !enable;
      reset = ($urandom_range(0, 4999) == 0);
      step();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    presc_div = '0;
    upd_valid = 1'b0;
    upd_duty  = '0;
    mValid    = 1'b0;
    mRun      = 1'b0;
    mDrain    = 1'b0;
    mPend     = 1'b0;
    mStart    = 0;
    mDiv      = 0;
    cyc       = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      mDuty[i]    = 0;
      mPendVal[i] = 0;
    end
    @(negedge clk);
    test_reset();
    test_basic();
    test_midframe_update();
    test_wrap_offer();
    test_presc_change();
    test_drain();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
